mp_node_gen2: RTL and testbench
===============================

Name: mp_node_gen2

Overview:
Parametrised second-generation interposer node for the multipoint ring/bus fabric. It supports NUM_CH channels, each with a per-channel injection FIFO, a 3-bit arbiter control, registered outgoing drivers and request generation. All channels share one ejection FIFO toward the local chiplet. Compared with the first-generation node it adds configurable width, channel count and queue depths, host-side valid/ready handshakes, backpressure, and error flags.

Parameters:
NODE_NUMBER, 0, this node's ID; compared against the message dest field.
NUM_CH, 2, number of fabric channels.
MSG_W, 22, fabric message width.
DEST_W, 4, width of the node ID field.
TXQ_DEPTH, 4, entries per injection FIFO (power of 2, >=2).
RXQ_DEPTH, 4, ejection FIFO entries (power of 2, >=2).
Derived (localparam): PAY_W = MSG_W-1-2*DEST_W, which is 13 at the defaults.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high.
ctrl_in  in  3*NUM_CH  per-channel arbiter control; bit2 = grant-send, bit1 = receive, bit0 = bypass.
msg_in  in  MSG_W*NUM_CH  incoming fabric messages.
msg_out  out  MSG_W*NUM_CH  outgoing fabric messages, registered.
req_valid  out  NUM_CH  per-channel send request.
req_dest  out  DEST_W*NUM_CH  destination of the head entry of each injection FIFO.
tx_valid  in  1  host push.
tx_ready  out  1  the FIFO addressed by tx_ch is not full.
tx_ch  in  clog2(NUM_CH) (min 1)  target channel for the push.
tx_dest  in  DEST_W  destination node.
tx_payload  in  PAY_W  payload.
rx_valid  out  1  ejection FIFO not empty.
rx_ready  in  1  host pop.
rx_data  out  MSG_W  head of the ejection FIFO (full message).
rx_full  out  1  ejection FIFO full; the arbiter must not issue receive while this is high.
err_flags  out  3  sticky error flags; bit0 = rx overflow drop, bit1 = misrouted receive, bit2 = ctrl conflict.

Behaviour:
- Message format: [MSG_W-1] = valid, then dest (DEST_W bits), then src (DEST_W bits), then payload (PAY_W bits) in the LSBs.
- Reset: FIFOs empty, msg_out = 0, err_flags = 0. Consequently req_valid = 0, rx_valid = 0 and tx_ready = 1. Reset mid-operation discards every queued entry and every in-flight output.
- Push: a push occurs when tx_valid & tx_ready. The entry {tx_dest, tx_payload} is written to FIFO[tx_ch]. If tx_ch >= NUM_CH, the push is ignored and tx_ready = 0.
- Request: req_valid[c] = FIFO[c] not empty, and req_dest[c] = the head entry's dest. Both are combinational from the FIFO state, so a request is visible in the cycle after the push.
- Control priority per channel, evaluated at each edge: send > receive > bypass.
  - More than one control bit set: apply the highest-priority action and set err bit2.
- Send (bit2): if req_valid[c] is high, pop FIFO[c]. msg_out[c] becomes {1, dest, NODE_NUMBER, payload} after one cycle of latency. If the FIFO is empty, msg_out[c] = 0 and nothing pops.
- Receive (bit1): incoming messages with valid = 0 are ignored. For a valid message:
  - dest == NODE_NUMBER and the RX FIFO is not full: push the whole message.
  - dest == NODE_NUMBER and the RX FIFO is full: drop it and set err bit0.
  - dest != NODE_NUMBER: drop it and set err bit1.
  - msg_out[c] = 0 on the next cycle.
- RX arbitration: when several channels receive in the same cycle, the lowest channel index is pushed first, up to the free space. Any excess messages are dropped with err bit0 set. The implementation supports at most NUM_CH pushes per cycle.
- Bypass (bit0): msg_out[c] <= msg_in[c], one-cycle latency, no checks.
- Idle: when no control bit is set, msg_out[c] <= 0.
- Pop: rx_ready & rx_valid pops the RX FIFO. A simultaneous push and pop on a full FIFO is allowed: the pop frees space for the push in the same cycle, so there is no drop.
- Pointers wrap modulo the depth, with a full/empty distinction kept by an extra pointer bit.
- err_flags clear only on reset.

Test Plan:
- Send: NODE_NUMBER=4. After reset, push tx_ch=0, tx_dest=6, tx_payload=0x0ABC. The next cycle shows req_valid[0]=1 and req_dest[0]=6. Raising ctrl ch0=3'b100 for one cycle gives msg_out[0]=0x2C8ABC on the following cycle, after which req_valid[0]=0.
- Receive: ctrl ch1=3'b010 with msg_in[1]=0x284155 (dest 4, src 2, payload 0x155). Next cycle rx_valid=1, rx_data=0x284155 and msg_out[1]=0. Pulsing rx_ready gives rx_valid=0.
- Bypass: ctrl ch1=3'b001 with msg_in[1]=0x2A1234 gives msg_out[1]=0x2A1234 the next cycle, no RX push, and err_flags=0.
- Backpressure: fill FIFO ch0 with 4 pushes, after which tx_ready=0 and a 5th push is ignored. Then receive 4 messages addressed to node 4, giving rx_full=1. A 5th receive is dropped and err_flags[0]=1.
- Errors and priority: ctrl ch0=3'b111 with the queue non-empty results in a send, err bit2 set and no RX push. A receive of dest 5 at node 4 sets err bit1.
- Reset mid-run: with 2 entries queued and rx_valid=1, assert reset for 1 cycle. Result: req_valid=0, rx_valid=0, msg_out=0 and err_flags=0.

Source files
------------

// File: rtl/mp_node_gen2.sv
// Multipoint ring/bus interposer node: per-channel injection FIFOs, registered fabric
// drivers, per-channel send/receive/bypass control and one shared ejection FIFO.
module mp_node_gen2 #(
    parameter int NODE_NUMBER = 0,
    parameter int NUM_CH      = 2,
    parameter int MSG_W       = 22,
    parameter int DEST_W      = 4,
    parameter int TXQ_DEPTH   = 4,
    parameter int RXQ_DEPTH   = 4,
    localparam int PAY_W      = MSG_W - 1 - 2 * DEST_W,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*NUM_CH-1:0]        ctrl_in,
    input  logic [MSG_W*NUM_CH-1:0]    msg_in,
    output logic [MSG_W*NUM_CH-1:0]    msg_out,
    output logic [NUM_CH-1:0]          req_valid,
    output logic [DEST_W*NUM_CH-1:0]   req_dest,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [CH_W-1:0]            tx_ch,
    input  logic [DEST_W-1:0]          tx_dest,
    input  logic [PAY_W-1:0]           tx_payload,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [MSG_W-1:0]           rx_data,
    output logic                       rx_full,
    output logic [2:0]                 err_flags
);

    localparam int ENT_W = DEST_W + PAY_W;
    localparam int TAW   = $clog2(TXQ_DEPTH);
    localparam int RAW   = $clog2(RXQ_DEPTH);
    localparam int SW    = $clog2(RXQ_DEPTH + NUM_CH + 1) + 1;
    localparam logic [DEST_W-1:0] NODE_ID = DEST_W'(NODE_NUMBER);

    logic [NUM_CH-1:0] tx_full;
    logic [NUM_CH-1:0] rx_cand;
    logic [NUM_CH-1:0] rx_misroute;
    logic [NUM_CH-1:0] ctrl_conflict;
    logic [NUM_CH-1:0] rx_accept;
    logic [RAW-1:0]    rx_widx [NUM_CH];

    // Host push port: a channel index outside the fabric never reports ready.
    always_comb begin
        tx_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tx_ch == CH_W'(c)) begin
                tx_ready = !tx_full[c];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ENT_W-1:0]  txq_mem [TXQ_DEPTH];
            logic [TAW:0]      tx_wr_reg;
            logic [TAW:0]      tx_rd_reg;
            logic [MSG_W-1:0]  msg_reg;
            logic [2:0]        ctrl;
            logic [MSG_W-1:0]  msg_rcv;
            logic [DEST_W-1:0] rcv_dest;
            logic [ENT_W-1:0]  head;
            logic              empty;
            logic              full;
            logic              push;
            logic              do_send;
            logic              do_recv;
            logic              do_byp;

            assign ctrl     = ctrl_in[3*gi +: 3];
            assign msg_rcv  = msg_in[MSG_W*gi +: MSG_W];
            assign rcv_dest = msg_rcv[MSG_W-2 -: DEST_W];
            assign empty    = (tx_wr_reg == tx_rd_reg);
            assign full     = (tx_wr_reg[TAW] != tx_rd_reg[TAW]) &&
                              (tx_wr_reg[TAW-1:0] == tx_rd_reg[TAW-1:0]);
            assign head     = txq_mem[tx_rd_reg[TAW-1:0]];
            assign push     = tx_valid && !full && (tx_ch == CH_W'(gi));

            // Send outranks receive, which outranks bypass.
            assign do_send  = ctrl[2];
            assign do_recv  = ctrl[1] && !ctrl[2];
            assign do_byp   = ctrl[0] && !ctrl[1] && !ctrl[2];

            assign ctrl_conflict[gi] = (ctrl[2] && ctrl[1]) || (ctrl[2] && ctrl[0]) ||
                                       (ctrl[1] && ctrl[0]);
            assign rx_cand[gi]       = do_recv && msg_rcv[MSG_W-1] && (rcv_dest == NODE_ID);
            assign rx_misroute[gi]   = do_recv && msg_rcv[MSG_W-1] && (rcv_dest != NODE_ID);

            assign tx_full[gi]                     = full;
            assign req_valid[gi]                   = !empty;
            assign req_dest[DEST_W*gi +: DEST_W]   = head[ENT_W-1 -: DEST_W];
            assign msg_out[MSG_W*gi +: MSG_W]      = msg_reg;

            always_ff @(posedge clk) begin
                if (push) begin
                    txq_mem[tx_wr_reg[TAW-1:0]] <= {tx_dest, tx_payload};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    tx_wr_reg <= '0;
                    tx_rd_reg <= '0;
                    msg_reg   <= '0;
                end else begin
                    if (push) begin
                        tx_wr_reg <= tx_wr_reg + 1'b1;
                    end
                    if (do_send && !empty) begin
                        tx_rd_reg <= tx_rd_reg + 1'b1;
                        msg_reg   <= {1'b1, head[ENT_W-1 -: DEST_W], NODE_ID, head[PAY_W-1:0]};
                    end else if (do_byp) begin
                        msg_reg   <= msg_rcv;
                    end else begin
                        msg_reg   <= '0;
                    end
                end
            end
        end
    endgenerate

    logic [MSG_W-1:0] rxq_mem [RXQ_DEPTH];
    logic [RAW:0]     rx_wr_reg;
    logic [RAW:0]     rx_rd_reg;
    logic [RAW:0]     rx_count;
    logic [2:0]       err_flags_reg;
    logic             rx_pop;
    logic             rx_overflow;
    logic [SW-1:0]    rx_free;
    logic [SW-1:0]    rx_n;

    assign rx_count  = rx_wr_reg - rx_rd_reg;
    assign rx_valid  = (rx_count != '0);
    assign rx_full   = (rx_count == (RAW+1)'(RXQ_DEPTH));
    assign rx_data   = rxq_mem[rx_rd_reg[RAW-1:0]];
    assign rx_pop    = rx_ready && rx_valid;
    assign err_flags = err_flags_reg;

    // Same-cycle pop frees a slot; receiving channels claim slots lowest index first.
    always_comb begin
        rx_free     = SW'(RXQ_DEPTH) - SW'(rx_count) + SW'(rx_pop);
        rx_n        = '0;
        rx_overflow = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            rx_accept[c] = 1'b0;
            rx_widx[c]   = '0;
            if (rx_cand[c]) begin
                if (rx_n < rx_free) begin
                    rx_accept[c] = 1'b1;
                    rx_widx[c]   = rx_wr_reg[RAW-1:0] + RAW'(rx_n);
                    rx_n         = rx_n + SW'(1);
                end else begin
                    rx_overflow  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rx_accept[c]) begin
                rxq_mem[rx_widx[c]] <= msg_in[MSG_W*c +: MSG_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_reg     <= '0;
            rx_rd_reg     <= '0;
            err_flags_reg <= '0;
        end else begin
            rx_wr_reg     <= rx_wr_reg + (RAW+1)'(rx_n);
            rx_rd_reg     <= rx_rd_reg + (RAW+1)'(rx_pop);
            err_flags_reg <= err_flags_reg | {(|ctrl_conflict), (|rx_misroute), rx_overflow};
        end
    end

endmodule

// File: tb/tb_mp_node_gen2.sv
// Directed bench for mp_node_gen2 at NODE_NUMBER=4: expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_mp_node_gen2;

    logic        clk;
    logic        reset;
    logic [5:0]  ctrl_in;
    logic [43:0] msg_in;
    logic [43:0] msg_out;
    logic [1:0]  req_valid;
    logic [7:0]  req_dest;
    logic        tx_valid;
    logic        tx_ready;
    logic [0:0]  tx_ch;
    logic [3:0]  tx_dest;
    logic [12:0] tx_payload;
    logic        rx_valid;
    logic        rx_ready;
    logic [21:0] rx_data;
    logic        rx_full;
    logic [2:0]  err_flags;

    mp_node_gen2 #(.NODE_NUMBER(4)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .msg_in(msg_in), .msg_out(msg_out),
        .req_valid(req_valid), .req_dest(req_dest), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_ch(tx_ch), .tx_dest(tx_dest), .tx_payload(tx_payload), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_full(rx_full), .err_flags(err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("check %-16s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [21:0] mk(input logic [3:0] d, input logic [3:0] s,
                                       input logic [12:0] p);
        return {1'b1, d, s, p};
    endfunction

    logic [21:0] drain_exp [4];

    initial begin
        reset = 1'b1; ctrl_in = '0; msg_in = '0; tx_valid = 1'b0; tx_ch = '0;
        tx_dest = '0; tx_payload = '0; rx_ready = 1'b0;
        tick; tick;

        // Reset state
        sb_push("rst_req_valid", 0); sb_push("rst_rx_valid", 0); sb_push("rst_tx_ready", 1);
        sb_push("rst_msg_out", 0);   sb_push("rst_err", 0);
        sb_check(32'(req_valid)); sb_check(32'(rx_valid)); sb_check(32'(tx_ready));
        sb_check(32'(msg_out));   sb_check(32'(err_flags));
        reset = 1'b0;
        tick;

        // Send
        tx_valid = 1'b1; tx_ch = 1'b0; tx_dest = 4'd6; tx_payload = 13'h0ABC;
        sb_push("send_req_valid", 1); sb_push("send_req_dest", 6);
        tick;
        tx_valid = 1'b0;
        sb_check(32'(req_valid[0])); sb_check(32'(req_dest[3:0]));
        ctrl_in[2:0] = 3'b100;
        sb_push("send_msg_out", 32'h2C8ABC); sb_push("send_req_after", 0);
        tick;
        ctrl_in = '0;
        sb_check(32'(msg_out[21:0])); sb_check(32'(req_valid[0]));
        sb_push("idle_msg_out", 0);
        tick;
        sb_check(32'(msg_out[21:0]));

        // Receive
        ctrl_in[5:3] = 3'b010; msg_in[43:22] = 22'h284155;
        sb_push("recv_rx_valid", 1); sb_push("recv_rx_data", 32'h284155);
        sb_push("recv_msg_out", 0);
        tick;
        ctrl_in = '0;
        sb_check(32'(rx_valid)); sb_check(32'(rx_data)); sb_check(32'(msg_out[43:22]));
        rx_ready = 1'b1;
        sb_push("recv_pop", 0);
        tick;
        rx_ready = 1'b0;
        sb_check(32'(rx_valid));

        // Bypass
        ctrl_in[5:3] = 3'b001; msg_in[43:22] = 22'h2A1234;
        sb_push("byp_msg_out", 32'h2A1234); sb_push("byp_rx_valid", 0); sb_push("byp_err", 0);
        tick;
        ctrl_in = '0;
        sb_check(32'(msg_out[43:22])); sb_check(32'(rx_valid)); sb_check(32'(err_flags));

        // Backpressure on injection FIFO 0
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_ch = 1'b0; tx_dest = 4'd3; tx_payload = 13'h100 + 13'(i);
            tick;
        end
        tx_payload = 13'h1FF;
        sb_push("bp_tx_ready", 0);
        sb_check(32'(tx_ready));
        tick;
        tx_valid = 1'b0;
        ctrl_in[2:0] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            sb_push("bp_send", 32'(mk(4'd3, 4'd4, 13'h100 + 13'(i))));
            tick;
            sb_check(32'(msg_out[21:0]));
        end
        ctrl_in = '0;
        sb_push("bp_drained", 0);
        sb_check(32'(req_valid[0]));

        // Fill the ejection FIFO from both channels at once
        ctrl_in = 6'b010_010;
        msg_in = {mk(4'd4, 4'd1, 13'h0B), mk(4'd4, 4'd0, 13'h0A)};
        tick;
        msg_in = {mk(4'd4, 4'd1, 13'h0D), mk(4'd4, 4'd0, 13'h0C)};
        tick;
        ctrl_in = '0;
        sb_push("fill_rx_full", 1); sb_push("fill_err", 0); sb_push("fill_head", 32'(mk(4'd4, 4'd0, 13'h0A)));
        sb_check(32'(rx_full)); sb_check(32'(err_flags)); sb_check(32'(rx_data));

        // Push and pop together on a full FIFO
        ctrl_in[2:0] = 3'b010; msg_in[21:0] = mk(4'd4, 4'd0, 13'h0F); rx_ready = 1'b1;
        sb_push("pp_rx_full", 1); sb_push("pp_err", 0); sb_push("pp_head", 32'(mk(4'd4, 4'd1, 13'h0B)));
        tick;
        ctrl_in = '0; rx_ready = 1'b0;
        sb_check(32'(rx_full)); sb_check(32'(err_flags)); sb_check(32'(rx_data));

        // Overflow drop
        ctrl_in[5:3] = 3'b010; msg_in[43:22] = mk(4'd4, 4'd1, 13'h0E);
        sb_push("ovf_err", 3'b001);
        tick;
        ctrl_in = '0;
        sb_check(32'(err_flags));

        drain_exp[0] = mk(4'd4, 4'd1, 13'h0B);
        drain_exp[1] = mk(4'd4, 4'd0, 13'h0C);
        drain_exp[2] = mk(4'd4, 4'd1, 13'h0D);
        drain_exp[3] = mk(4'd4, 4'd0, 13'h0F);
        for (int i = 0; i < 4; i++) begin
            sb_push("drain_data", 32'(drain_exp[i]));
            sb_check(32'(rx_data));
            rx_ready = 1'b1;
            tick;
            rx_ready = 1'b0;
        end
        sb_push("drain_empty", 0);
        sb_check(32'(rx_valid));

        reset = 1'b1;
        tick;
        reset = 1'b0;
        sb_push("rst2_err", 0);
        sb_check(32'(err_flags));

        // Priority: send wins over receive and bypass, conflict flagged
        tx_valid = 1'b1; tx_ch = 1'b0; tx_dest = 4'd7; tx_payload = 13'h055;
        tick;
        tx_valid = 1'b0;
        ctrl_in[2:0] = 3'b111; msg_in[21:0] = mk(4'd4, 4'd2, 13'h033);
        sb_push("pri_msg_out", 32'(mk(4'd7, 4'd4, 13'h055)));
        sb_push("pri_err", 3'b100); sb_push("pri_rx_valid", 0); sb_push("pri_req_valid", 0);
        tick;
        ctrl_in = '0;
        sb_check(32'(msg_out[21:0])); sb_check(32'(err_flags));
        sb_check(32'(rx_valid));      sb_check(32'(req_valid[0]));

        // Misrouted receive
        ctrl_in[5:3] = 3'b010; msg_in[43:22] = mk(4'd5, 4'd2, 13'h044);
        sb_push("mis_err", 3'b110); sb_push("mis_rx_valid", 0); sb_push("mis_msg_out", 0);
        tick;
        ctrl_in = '0;
        sb_check(32'(err_flags)); sb_check(32'(rx_valid)); sb_check(32'(msg_out[43:22]));

        // Invalid messages are ignored
        ctrl_in[5:3] = 3'b010; msg_in[43:22] = {1'b0, 4'd4, 4'd2, 13'h044};
        sb_push("inv_rx_valid", 0); sb_push("inv_err", 3'b110);
        tick;
        ctrl_in = '0;
        sb_check(32'(rx_valid)); sb_check(32'(err_flags));

        // Reset mid-run
        tx_valid = 1'b1; tx_ch = 1'b0; tx_dest = 4'd2; tx_payload = 13'h011;
        ctrl_in[5:3] = 3'b010; msg_in[43:22] = mk(4'd4, 4'd3, 13'h077);
        tick;
        ctrl_in = '0; tx_payload = 13'h012;
        tick;
        tx_valid = 1'b0;
        sb_push("mid_req_valid", 1); sb_push("mid_rx_valid", 1);
        sb_check(32'(req_valid[0])); sb_check(32'(rx_valid));
        reset = 1'b1; ctrl_in = 6'b001_100; msg_in[43:22] = 22'h2A1234;
        sb_push("mid_rst_req", 0); sb_push("mid_rst_rx", 0); sb_push("mid_rst_msg", 0);
        sb_push("mid_rst_err", 0); sb_push("mid_rst_txrdy", 1);
        tick;
        reset = 1'b0; ctrl_in = '0;
        sb_check(32'(req_valid)); sb_check(32'(rx_valid)); sb_check(32'(msg_out));
        sb_check(32'(err_flags)); sb_check(32'(tx_ready));

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
